// File: rtl/bilinear_pkg.sv
// Shared definitions for the BRAM line buffer: slot geometry and the pair-read FSM encoding.
package bilinear_pkg;

  localparam int SLOT_NUM = 4;
  localparam int SLOT_W   = $clog2(SLOT_NUM);
  localparam int AVAIL_W  = 3;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_TOP = 2'd1,
    ST_RD_BOT = 2'd2,
    ST_FLUSH  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/bram_linebuf_ctrl_if.sv
// Pixel stream in, pixel pair out and both BRAM ports of the line buffer controller.
interface bram_linebuf_ctrl_if #(
  parameter int C_COL_WIDTH  = 11,
  parameter int C_DATA_WIDTH = 8
);
  import bilinear_pkg::*;

  localparam int ADDR_W = C_COL_WIDTH + SLOT_W;

  logic                    s_valid;
  logic                    s_ready;
  logic [C_DATA_WIDTH-1:0] s_data;
  logic                    s_last;

  logic                    m_valid;
  logic [C_DATA_WIDTH-1:0] m_top;
  logic [C_DATA_WIDTH-1:0] m_bot;
  logic                    m_last;

  logic                    wea;
  logic [ADDR_W-1:0]       addra;
  logic [C_DATA_WIDTH-1:0] dina;
  logic                    web;
  logic [ADDR_W-1:0]       addrb;
  logic [C_DATA_WIDTH-1:0] doutb;

  // Controller side.
  modport slave (
    input  s_valid, s_data, s_last, doutb,
    output s_ready, m_valid, m_top, m_bot, m_last,
    output wea, addra, dina, web, addrb
  );

  // Source, sink and RAM side.
  modport master (
    output s_valid, s_data, s_last, doutb,
    input  s_ready, m_valid, m_top, m_bot, m_last,
    input  wea, addra, dina, web, addrb
  );

endinterface

// File: rtl/lbuf_slot_tracker.sv
// Ring bookkeeping for the four line slots: write slot, read slot and filled-line count.
module lbuf_slot_tracker
  import bilinear_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_done,
  input  logic               rd_release,
  input  logic               rd_busy,
  output slot_t              wr_slot,
  output slot_t              rd_slot,
  output logic [AVAIL_W-1:0] lines_avail
);

  logic release_ok;

  assign release_ok = rd_release && !rd_busy && (lines_avail != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_slot     <= '0;
      rd_slot     <= '0;
      lines_avail <= '0;
    end else begin
      if (line_done)  wr_slot <= wr_slot + slot_t'(1);
      if (release_ok) rd_slot <= rd_slot + slot_t'(1);
      // A fill and a release in the same cycle cancel out.
      case ({line_done, release_ok})
        2'b10:   lines_avail <= lines_avail + AVAIL_W'(1);
        2'b01:   lines_avail <= lines_avail - AVAIL_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_linebuf_ctrl.sv
// Four-slot BRAM line buffer: writes a pixel stream line by line and reads two lines back as pixel pairs.
// Define LBUF_OUT_REG_EN to add one output register stage (pair latency 4 instead of 3).
module bram_linebuf_ctrl
  import bilinear_pkg::*;
#(
  parameter int C_COL_WIDTH  = 11,
  parameter int C_DATA_WIDTH = 8,
  parameter int C_SLOT_NUM   = SLOT_NUM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [C_COL_WIDTH-1:0] line_len,
  input  logic                   rd_start,
  input  logic                   rd_release,
  output logic                   rd_busy,
  output logic [AVAIL_W-1:0]     lines_avail,
  bram_linebuf_ctrl_if.slave     bus
);

  slot_t                   wr_slot;
  slot_t                   rd_slot;
  slot_t                   bot_slot;
  logic                    rst_done;
  logic                    accept;
  logic                    line_done;
  logic [C_COL_WIDTH-1:0]  wr_col;
  logic [C_COL_WIDTH-1:0]  wr_len_q;
  logic [C_COL_WIDTH-1:0]  wr_len;

  rd_state_e               state;
  rd_state_e               next_state;
  logic                    start_ok;
  logic                    pair_set;
  logic [C_COL_WIDTH-1:0]  rd_col;
  logic [C_COL_WIDTH-1:0]  rd_len_q;
  logic [C_DATA_WIDTH-1:0] top_q;
  logic                    pair_vld;
  logic                    pair_last;
  logic [C_DATA_WIDTH-1:0] pair_bot;

  lbuf_slot_tracker u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_done   (line_done),
    .rd_release  (rd_release),
    .rd_busy     (rd_busy),
    .wr_slot     (wr_slot),
    .rd_slot     (rd_slot),
    .lines_avail (lines_avail)
  );

  // Write side: s_ready stays low while reset is asserted so nothing can be written.
  assign bus.s_ready = rst_done && (lines_avail < AVAIL_W'(C_SLOT_NUM));
  assign accept      = bus.s_valid && bus.s_ready;
  assign wr_len      = (wr_col == '0) ? line_len : wr_len_q;
  assign line_done   = accept && (bus.s_last || (wr_col == wr_len));

  assign bus.wea   = accept;
  assign bus.addra = {wr_slot, wr_col};
  assign bus.dina  = bus.s_data;
  assign bus.web   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      wr_col   <= '0;
      wr_len_q <= '0;
    end else begin
      rst_done <= 1'b1;
      if (accept) begin
        if (wr_col == '0) wr_len_q <= line_len;
        wr_col <= line_done ? '0 : wr_col + C_COL_WIDTH'(1);
      end
    end
  end

  // Read side: alternate top/bottom addresses; the top pixel waits in top_q for its partner.
  assign bot_slot = rd_slot + slot_t'(1);
  assign start_ok = (state == ST_IDLE) && rd_start && (lines_avail >= AVAIL_W'(2));
  assign rd_busy  = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block is assigned a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    bus.addrb  = {rd_slot, rd_col};
    pair_set   = 1'b0;
    case (state)
      ST_IDLE:   if (start_ok) next_state = ST_RD_TOP;
      ST_RD_TOP: next_state = ST_RD_BOT;
      ST_RD_BOT: begin
        bus.addrb  = {bot_slot, rd_col};
        pair_set   = 1'b1;
        next_state = (rd_col == rd_len_q) ? ST_FLUSH : ST_RD_TOP;
      end
      ST_FLUSH:  next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_col    <= '0;
      rd_len_q  <= '0;
      top_q     <= '0;
      pair_vld  <= 1'b0;
      pair_last <= 1'b0;
    end else begin
      if (start_ok) begin
        rd_col   <= '0;
        rd_len_q <= line_len;
      end
      if (state == ST_RD_BOT) begin
        top_q <= bus.doutb;
        if (rd_col != rd_len_q) rd_col <= rd_col + C_COL_WIDTH'(1);
      end
      pair_vld  <= pair_set;
      pair_last <= pair_set && (rd_col == rd_len_q);
    end
  end

  // The bottom pixel comes straight from the RAM in the cycle it is valid.
  assign pair_bot = pair_vld ? bus.doutb : '0;

`ifdef LBUF_OUT_REG_EN
  logic                    out_vld;
  logic                    out_last;
  logic [C_DATA_WIDTH-1:0] out_top;
  logic [C_DATA_WIDTH-1:0] out_bot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_top  <= '0;
      out_bot  <= '0;
    end else begin
      out_vld  <= pair_vld;
      out_last <= pair_last;
      out_top  <= top_q;
      out_bot  <= pair_bot;
    end
  end

  assign bus.m_valid = out_vld;
  assign bus.m_last  = out_last;
  assign bus.m_top   = out_top;
  assign bus.m_bot   = out_bot;
`else
  assign bus.m_valid = pair_vld;
  assign bus.m_last  = pair_last;
  assign bus.m_top   = top_q;
  assign bus.m_bot   = pair_bot;
`endif

endmodule

// File: tb/tb_bram_linebuf_ctrl.sv
// Directed/randomised bench for bram_linebuf_ctrl with a line-queue reference model and a BRAM model.
module tb_bram_linebuf_ctrl;
  import bilinear_pkg::*;

  localparam int CW     = 11;
  localparam int DW     = 8;
  localparam int AW     = CW + 2;
  localparam int MAXLEN = 16;
`ifdef LBUF_OUT_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef logic [MAXLEN-1:0][DW-1:0] line_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] line_len = '0;
  logic          rd_start = 1'b0;
  logic          rd_release = 1'b0;
  logic          rd_busy;
  logic [2:0]    lines_avail;

  bram_linebuf_ctrl_if #(.C_COL_WIDTH(CW), .C_DATA_WIDTH(DW)) bus ();

  bram_linebuf_ctrl #(.C_COL_WIDTH(CW), .C_DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_len    (line_len),
    .rd_start    (rd_start),
    .rd_release  (rd_release),
    .rd_busy     (rd_busy),
    .lines_avail (lines_avail),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Dual-port BRAM: write port A, registered read port B.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.wea) ram[bus.addra] <= bus.dina;
    bus.doutb <= ram[bus.addrb];
  end

  // Reference model: filled lines oldest first, plus the total count of lines written.
  line_t stored[$];
  int    lines_written = 0;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes n pixels with line_len = ll-1; s_last on the final pixel; optional release on the last beat.
  task automatic write_line(input int n, input int ll, input bit rel_last, input int base);
    line_t ln;
    logic [AW-1:0] ea;
    ln = '0;
    line_len = CW'(ll - 1);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        rd_release  = 1'b0;
        tick();
      end
      ln[i] = (base < 0) ? DW'($urandom) : DW'(base + i);
      bus.s_valid = 1'b1;
      bus.s_data  = ln[i];
      bus.s_last  = (i == n - 1);
      rd_release  = rel_last && (i == n - 1);
      #1;
      ea = {2'(lines_written % 4), CW'(i)};
      check("s_ready", bus.s_ready, 1);
      check("wea", bus.wea, 1);
      check("addra", bus.addra, ea);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    rd_release  = 1'b0;
    if (rel_last && stored.size() > 0) void'(stored.pop_front());
    stored.push_back(ln);
    lines_written++;
    check("lines_avail_wr", lines_avail, stored.size());
  endtask

  task automatic release_line();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    if (stored.size() > 0) void'(stored.pop_front());
    check("lines_avail_rel", lines_avail, stored.size());
  endtask

  // Reads the two oldest lines of n pixels and checks every pair, its timing and m_last.
  task automatic read_pair(input int n);
    line_t top, bot;
    int    k;
    top = stored[0];
    bot = stored[1];
    line_len = CW'(n - 1);
    rd_start = 1'b1;
    k = 0;
    for (int cyc = 1; cyc <= LAT + 2 * n + 6; cyc++) begin
      tick();
      rd_start = 1'b0;
      if (cyc == 1) check("rd_busy_start", rd_busy, 1);
      if (bus.m_valid === 1'b1) begin
        check("pair_time", cyc, LAT + 2 * k);
        if (k < n) begin
          check("m_top", bus.m_top, top[k]);
          check("m_bot", bus.m_bot, bot[k]);
          check("m_last", bus.m_last, (k == n - 1));
        end
        k++;
      end
    end
    check("pair_count", k, n);
    check("rd_busy_end", rd_busy, 0);
    check("lines_avail_rd", lines_avail, stored.size());
  endtask

  initial begin
    int len;
    int pulses;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset state, with s_valid held high to make sure nothing is written.
    repeat (3) tick();
    bus.s_valid = 1'b1;
    #1;
    check("rst_wea", bus.wea, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_top", bus.m_top, 0);
    check("rst_m_bot", bus.m_bot, 0);
    check("rst_rd_busy", rd_busy, 0);
    check("rst_lines_avail", lines_avail, 0);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    check("s_ready_after_rst", bus.s_ready, 1);
    check("web", bus.web, 0);

    // Two 8-pixel lines 0..7 and 8..15, one pair read.
    write_line(8, 8, 1'b0, 0);
    write_line(8, 8, 1'b0, 8);
    read_pair(8);
    release_line();
    release_line();

    // Only one line stored: rd_start is ignored.
    write_line(5, 5, 1'b0, -1);
    rd_start = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      rd_start = 1'b0;
      if (bus.m_valid !== 1'b0 || rd_busy !== 1'b0) pulses++;
    end
    check("one_line_no_read", pulses, 0);
    check("one_line_avail", lines_avail, 1);

    // Fill all four slots: back-pressure, then a release reopens the input.
    write_line(5, 5, 1'b0, -1);
    write_line(5, 5, 1'b0, -1);
    write_line(5, 5, 1'b0, -1);
    check("full_s_ready", bus.s_ready, 0);
    check("full_avail", lines_avail, 4);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    #1;
    check("full_wea", bus.wea, 0);
    tick();
    bus.s_valid = 1'b0;
    check("full_avail_hold", lines_avail, 4);
    release_line();
    check("s_ready_after_rel", bus.s_ready, 1);
    release_line();

    // Line completion and release in the same cycle with two lines stored.
    write_line(5, 5, 1'b1, -1);
    check("same_cycle_avail", lines_avail, 2);
    read_pair(5);
    release_line();
    release_line();

    // Early s_last ends a line before line_len is reached.
    write_line(4, 16, 1'b0, -1);
    release_line();

    // Three pair rounds with random lengths; slot indices wrap through 3 -> 0.
    for (int p = 0; p < 3; p++) begin
      len = $urandom_range(2, MAXLEN);
      write_line(len, len, 1'b0, -1);
      write_line(len, len, 1'b0, -1);
      read_pair(len);
      release_line();
      release_line();
    end

    // Reset in the middle of a pair read.
    write_line(8, 8, 1'b0, -1);
    write_line(8, 8, 1'b0, -1);
    line_len = CW'(7);
    rd_start = 1'b1;
    repeat (4) begin
      tick();
      rd_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrd_m_valid", bus.m_valid, 0);
    check("midrd_rd_busy", rd_busy, 0);
    check("midrd_avail", lines_avail, 0);
    check("midrd_m_last", bus.m_last, 0);
    tick();
    rst_n = 1'b1;
    stored.delete();
    lines_written = 0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.m_valid !== 1'b0) pulses++;
    end
    check("post_rst_no_pulse", pulses, 0);
    check("post_rst_busy", rd_busy, 0);
    check("post_rst_s_ready", bus.s_ready, 1);
    write_line(6, 6, 1'b0, -1);
    write_line(6, 6, 1'b0, -1);
    read_pair(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
